// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared constants and types for the tug-of-war game core
package tow_pkg;

  localparam int           NUM_LIGHTS    = 9;
  localparam logic [3:0]   CENTER_IDX    = 4'd4;
  localparam logic [3:0]   LAST_IDX      = 4'd8;
  localparam logic [3:0]   FIRST_IDX     = 4'd0;
  localparam int           MAX_SCORE_DEF = 7;

  typedef logic [NUM_LIGHTS-1:0] light_t;

endpackage

// File: rtl/tug_of_war_core_if.sv
// rtl/tug_of_war_core_if.sv - player inputs and playfield/score outputs of the game core
interface tug_of_war_core_if;
  import tow_pkg::*;

  logic       key_l;
  logic       key_r;
  light_t     lights;
  logic [3:0] bcd_l;
  logic [3:0] bcd_r;
  logic       win_l;
  logic       win_r;
  logic       match_over;

  modport master (
    output key_l, key_r,
    input  lights, bcd_l, bcd_r, win_l, win_r, match_over
  );

  modport slave (
    input  key_l, key_r,
    output lights, bcd_l, bcd_r, win_l, win_r, match_over
  );

endinterface

// File: rtl/tow_press_pulse.sv
// rtl/tow_press_pulse.sv - turns a synchronized button level into a one-cycle press pulse
module tow_press_pulse (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic key_q;
  logic pulse_q;
  logic pulse_d;

  assign pulse_d = key & ~key_q;
  assign pulse   = pulse_q;

  // key_q tracks the button even in reset so a held button never fires on release of reset
  always_ff @(posedge clk) begin
    key_q <= key;
    if (reset) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/tug_of_war_core.sv
// rtl/tug_of_war_core.sv - tug-of-war playfield, round wins and match scoring
module tug_of_war_core
  import tow_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  tug_of_war_core_if.slave   io
);

  logic       pl;
  logic       pr;
  logic [3:0] pos_q, pos_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       win_l_q, win_l_d;
  logic       win_r_q, win_r_d;
  logic       over;

  tow_press_pulse u_pulse_l (
    .clk   (clk),
    .reset (reset),
    .key   (io.key_l),
    .pulse (pl)
  );

  tow_press_pulse u_pulse_r (
    .clk   (clk),
    .reset (reset),
    .key   (io.key_r),
    .pulse (pr)
  );

  assign over = (score_l_q == 4'(MAX_SCORE)) || (score_r_q == 4'(MAX_SCORE));

  always_comb begin
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    win_l_d   = 1'b0;
    win_r_d   = 1'b0;
    if (!over) begin
      if (pl && !pr) begin
        if (pos_q == LAST_IDX) begin
          pos_d     = CENTER_IDX;
          score_l_d = score_l_q + 4'd1;
          win_l_d   = 1'b1;
        end else begin
          pos_d = pos_q + 4'd1;
        end
      end else if (pr && !pl) begin
        if (pos_q == FIRST_IDX) begin
          pos_d     = CENTER_IDX;
          score_r_d = score_r_q + 4'd1;
          win_r_d   = 1'b1;
        end else begin
          pos_d = pos_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q     <= CENTER_IDX;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
    end
  end

  always_comb begin
    io.lights = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      io.lights[i] = (pos_q == 4'(i));
    end
  end

  assign io.bcd_l      = score_l_q;
  assign io.bcd_r      = score_r_q;
  assign io.win_l      = win_l_q;
  assign io.win_r      = win_r_q;
  assign io.match_over = over;

endmodule

// File: tb/tb_tug_of_war_core.sv
// tb/tb_tug_of_war_core.sv - scoreboard bench for the tug-of-war game core
module tb_tug_of_war_core;

  localparam int MAXS = 7;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  tug_of_war_core_if io ();

  tug_of_war_core #(.MAX_SCORE(MAXS)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: expected outputs after each edge
  logic       m_kl_q, m_kr_q, m_pl, m_pr;
  int         m_pos;
  int         m_sl, m_sr;
  logic       m_wl, m_wr;
  logic [19:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model_pack();
    logic [8:0] l;
    logic       mo;
    l = 9'd0;
    l[m_pos] = 1'b1;
    mo = (m_sl == MAXS) || (m_sr == MAXS);
    return {l, 4'(m_sl), 4'(m_sr), m_wl, m_wr, mo};
  endfunction

  task automatic model_edge(input logic kl, input logic kr, input logic rst);
    if (rst) begin
      m_pos = 4; m_sl = 0; m_sr = 0; m_wl = 0; m_wr = 0;
      m_pl = 0; m_pr = 0;
    end else begin
      m_wl = 0; m_wr = 0;
      if (!(m_sl == MAXS || m_sr == MAXS)) begin
        if (m_pl && !m_pr) begin
          if (m_pos == 8) begin m_pos = 4; m_sl++; m_wl = 1; end
          else m_pos++;
        end else if (m_pr && !m_pl) begin
          if (m_pos == 0) begin m_pos = 4; m_sr++; m_wr = 1; end
          else m_pos--;
        end
      end
      m_pl = kl & ~m_kl_q;
      m_pr = kr & ~m_kr_q;
    end
    m_kl_q = kl;
    m_kr_q = kr;
  endtask

  task automatic step(input logic kl, input logic kr, input logic rst);
    logic [19:0] e;
    @(negedge clk);
    io.key_l = kl;
    io.key_r = kr;
    reset    = rst;
    model_edge(kl, kr, rst);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("cycle", {12'd0, io.lights, io.bcd_l, io.bcd_r, io.win_l, io.win_r, io.match_over},
               {12'd0, e});
    end
  endtask

  task automatic press_l();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic press_r();
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    io.key_l = 0;
    io.key_r = 0;
    reset    = 1;
    m_kl_q = 0; m_kr_q = 0; m_pl = 0; m_pr = 0;
    m_pos = 4; m_sl = 0; m_sr = 0; m_wl = 0; m_wr = 0;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    check_eq("reset_lights", 32'(io.lights), 32'h010);
    check_eq("reset_scores", {24'd0, io.bcd_l, io.bcd_r}, 32'd0);

    // Long hold gives a single step
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("hold_one_step", 32'(io.lights), 32'h020);

    // Left wins a round
    do_reset();
    for (int i = 0; i < 4; i++) press_l();
    check_eq("left_at_end", 32'(io.lights), 32'h100);
    step(1, 0, 0);
    step(0, 0, 0);
    check_eq("left_win_pulse", 32'(io.win_l), 32'd1);
    step(0, 0, 0);
    check_eq("left_win_score", 32'(io.bcd_l), 32'd1);
    check_eq("left_win_center", 32'(io.lights), 32'h010);
    check_eq("left_win_pulse_end", 32'(io.win_l), 32'd0);

    // Simultaneous presses at center and at the left end
    do_reset();
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("both_center", 32'(io.lights), 32'h010);
    for (int i = 0; i < 4; i++) press_l();
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("both_end_lights", 32'(io.lights), 32'h100);
    check_eq("both_end_scores", {24'd0, io.bcd_l, io.bcd_r}, 32'd0);

    // Right takes the match
    do_reset();
    for (int r = 0; r < MAXS; r++) begin
      for (int p = 0; p < 5; p++) press_r();
    end
    step(0, 0, 0);
    check_eq("match_score_r", 32'(io.bcd_r), 32'd7);
    check_eq("match_over", 32'(io.match_over), 32'd1);
    for (int i = 0; i < 3; i++) begin
      press_r();
      press_l();
    end
    step(0, 0, 0);
    check_eq("frozen_lights", 32'(io.lights), 32'h010);
    check_eq("frozen_scores", {24'd0, io.bcd_l, io.bcd_r}, 32'h07);
    do_reset();
    check_eq("post_match_reset", {16'd0, 3'd0, io.lights, io.bcd_l, io.bcd_r},
             {16'd0, 3'd0, 9'h010, 8'h00});
    check_eq("post_match_over", 32'(io.match_over), 32'd0);

    // Button held through reset release
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    check_eq("held_reset_lights", 32'(io.lights), 32'h010);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) press_l();
    check_eq("at_bit7", 32'(io.lights), 32'h080);
    step(0, 0, 1);
    check_eq("mid_round_reset", 32'(io.lights), 32'h010);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
